// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU-side SRAM bus: response owner, response FSM
// states and the default starvation limit.
package cpu_bus_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } resp_state_t;

endpackage

// File: rtl/rr_starve_grant.sv
// Single-winner grant between fetch and load/store. Data normally wins, but
// after STARVE_LIMIT data grants against a waiting fetch, the fetch wins.
module rr_starve_grant
  import cpu_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic inst_req,
  input  logic data_req,
  output logic inst_gnt,
  output logic data_gnt
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (!reset) begin
      data_gnt = data_req && !(inst_req && (starve_cnt == LIMIT));
      inst_gnt = inst_req && !data_gnt;
    end
  end

  // Counts data wins while fetch is waiting; any fetch grant or withdrawal clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!inst_req || inst_gnt) begin
      starve_cnt <= '0;
    end else if (data_gnt && (starve_cnt != LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates fetch and load/store onto one single-cycle-latency SRAM port and
// returns each granted access's data to its owner the following cycle.
module sram_port_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic        sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output resp_state_t dbg_state
);

  // Handshake: a request is accepted exactly in the cycle its addr_ok is high;
  // the matching data_ok pulses for one cycle on the next clock. Requests need
  // not be held, and an ungranted request may be withdrawn freely.

  logic        inst_gnt;
  logic        data_gnt;
  logic        any_gnt;
  resp_state_t state;
  resp_state_t state_nxt;
  owner_t      resp_owner;
  logic        resp_wr;
  logic        resp_active;

  rr_starve_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk      (clk),
    .reset    (reset),
    .inst_req (inst_req),
    .data_req (data_req),
    .inst_gnt (inst_gnt),
    .data_gnt (data_gnt)
  );

  assign any_gnt      = inst_gnt || data_gnt;
  assign inst_addr_ok = inst_gnt;
  assign data_addr_ok = data_gnt;

  assign sram_en    = any_gnt;
  assign sram_we    = data_gnt && data_wr;
  assign sram_wdata = (data_gnt && data_wr) ? data_wdata : 32'h0;
  assign sram_addr  = data_gnt ? data_addr : (inst_gnt ? inst_addr : 32'h0);

  always_comb begin
    state_nxt = state;
    if (any_gnt) begin
      state_nxt = RESP;
    end else begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      resp_owner <= OWN_INST;
      resp_wr    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (any_gnt) begin
        resp_owner <= data_gnt ? OWN_DATA : OWN_INST;
        resp_wr    <= data_gnt && data_wr;
      end
    end
  end

  // Gate on reset so a response pending when reset rises never leaks out.
  assign resp_active  = (state == RESP) && !reset;
  assign inst_data_ok = resp_active && (resp_owner == OWN_INST);
  assign data_data_ok = resp_active && (resp_owner == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? sram_rdata : 32'h0;
  assign data_rdata   = (data_data_ok && !resp_wr) ? sram_rdata : 32'h0;
  assign dbg_state    = resp_active ? RESP : IDLE;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based model of grants and one-cycle-later responses.
module tb_sram_port_arbiter;
  import cpu_bus_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en, sram_we;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  resp_state_t dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: pending responses as {owner_is_data, is_store}, and fetch wait count.
  logic [1:0] exp_q[$];
  int         starve = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a negedge: apply inputs and let combinational outputs settle.
  task automatic drive(input logic rst, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [31:0] srd);
    reset      = rst;
    inst_req   = ir;
    inst_addr  = ia;
    data_req   = dr;
    data_wr    = dw;
    data_addr  = da;
    data_wdata = dwd;
    sram_rdata = srd;
    #1;
  endtask

  // Compare every output against the model, then advance one clock.
  task automatic cycle_check();
    logic       d_win, i_win, have, r_data, r_store;
    logic [1:0] resp;
    if (reset) begin
      d_win = 1'b0;
      i_win = 1'b0;
      have  = 1'b0;
    end else begin
      d_win = data_req && !(inst_req && starve == LIMIT);
      i_win = inst_req && !d_win;
      have  = exp_q.size() > 0;
    end
    resp    = have ? exp_q[0] : 2'b00;
    r_data  = resp[1];
    r_store = resp[0];
    check("inst_addr_ok", inst_addr_ok, i_win);
    check("data_addr_ok", data_addr_ok, d_win);
    check("sram_en", sram_en, d_win || i_win);
    check("sram_we", sram_we, d_win && data_wr);
    check("sram_addr", sram_addr, d_win ? data_addr : (i_win ? inst_addr : 32'h0));
    check("sram_wdata", sram_wdata, (d_win && data_wr) ? data_wdata : 32'h0);
    check("inst_data_ok", inst_data_ok, have && !r_data);
    check("data_data_ok", data_data_ok, have && r_data);
    check("inst_rdata", inst_rdata, (have && !r_data) ? sram_rdata : 32'h0);
    check("data_rdata", data_rdata, (have && r_data && !r_store) ? sram_rdata : 32'h0);
    check("dbg_state", dbg_state, have ? RESP : IDLE);
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      starve = 0;
    end else begin
      if (have) void'(exp_q.pop_front());
      if (d_win || i_win) exp_q.push_back({d_win, d_win && data_wr});
      if (!inst_req || i_win) starve = 0;
      else if (d_win && starve < LIMIT) starve++;
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset held with requests active: nothing may be granted.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, $urandom, 1'b1, 1'($urandom), $urandom, $urandom, $urandom);
      cycle_check();
    end

    // Lone fetch, granted in the very first cycle out of reset.
    drive(1'b0, 1'b1, 32'h1c000000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    check("fetch_grant", inst_addr_ok, 1'b1);
    check("fetch_addr", sram_addr, 32'h1c000000);
    cycle_check();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h02800421);
    check("fetch_rdata", inst_rdata, 32'h02800421);
    cycle_check();

    // Simultaneous fetch and load: data first, fetch next.
    drive(1'b0, 1'b1, 32'h1c000004, 1'b1, 1'b0, 32'h00000100, 32'h0, 32'h0);
    check("both_data_first", data_addr_ok, 1'b1);
    cycle_check();
    drive(1'b0, 1'b1, 32'h1c000004, 1'b0, 1'b0, 32'h0, 32'h0, 32'h11112222);
    check("both_fetch_second", inst_addr_ok, 1'b1);
    check("both_load_ok", data_data_ok, 1'b1);
    cycle_check();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h33334444);
    check("both_fetch_ok", inst_data_ok, 1'b1);
    cycle_check();

    // Store: write enable and data in grant cycle, zero rdata with its data_ok.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 32'hdeadbeef, 32'h0);
    check("store_we", sram_we, 1'b1);
    check("store_wdata", sram_wdata, 32'hdeadbeef);
    cycle_check();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h5a5a5a5a);
    check("store_ok", data_data_ok, 1'b1);
    check("store_rdata", data_rdata, 32'h0);
    cycle_check();

    // Both held for ten cycles: fetch wins every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 32'h1c000100, 1'b1, 1'b0, 32'h200 + 32'(i), 32'h0, $urandom);
      check("starve_data_win", data_addr_ok, (i % 5) != 4);
      check("starve_inst_win", inst_addr_ok, (i % 5) == 4);
      cycle_check();
    end

    // Reset the cycle after a load grant: the pending response is dropped.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0);
    cycle_check();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h77777777);
    check("rst_mid_ok", data_data_ok, 1'b0);
    cycle_check();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h88888888);
    check("rst_after_ok", data_data_ok, 1'b0);
    cycle_check();

    // Idle bus.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'($urandom), $urandom, $urandom, $urandom);
      check("idle_en", sram_en, 1'b0);
      cycle_check();
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, $urandom,
            $urandom_range(0, 2) != 0, 1'($urandom), $urandom, $urandom, $urandom);
      cycle_check();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
